// File: rtl/title_arb_pkg.sv
// Shared types and sizes for the title-screen SRAM arbiter.
package title_arb_pkg;
  localparam int SRAM_AW         = 20;
  localparam int SRAM_DW         = 16;
  localparam int DEF_FRAME_WORDS = 153600;

  typedef enum logic [1:0] {IDLE, DISP_ACC, HOST_ACC, TURN} arb_state_t;
endpackage

// File: rtl/title_fifo.sv
// Show-ahead FIFO; when empty the head keeps presenting the last word popped.
module title_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/title_sram_arbiter.sv
// Shares one SRAM between the title display prefetch and the host port.
module title_sram_arbiter
  import title_arb_pkg::*;
#(
  parameter int                 FIFO_DEPTH    = 16,
  parameter int                 LOW_WATER     = 4,
  parameter int                 ACCESS_CYCLES = 2,
  parameter int                 FRAME_WORDS   = DEF_FRAME_WORDS,
  parameter logic [SRAM_AW-1:0] BASE_ADDR     = '0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               pop,
  output logic [SRAM_DW-1:0] word_out,
  output logic               word_valid,
  output logic               underflow,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [SRAM_AW-1:0] host_addr,
  input  logic [SRAM_DW-1:0] host_wdata,
  output logic               host_ack,
  output logic [SRAM_DW-1:0] host_rdata,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  input  logic [SRAM_DW-1:0] SRAM_DQ_in,
  output logic [SRAM_DW-1:0] SRAM_DQ_out,
  output logic               SRAM_DQ_oe
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int FCW = $clog2(FRAME_WORDS + 1);
  localparam int ACW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  arb_state_t   state, state_nxt;
  logic [ACW-1:0] acc_cnt;
  logic [FCW-1:0] fetch_cnt;
  logic [SRAM_AW-1:0] addr_q;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    occ;
  logic fifo_empty, fifo_full, fifo_push;
  logic last_cyc, disp_more, inflight, flush_pend;
  logic grant_disp, grant_host, ack_q, underflow_q;
  logic [SRAM_DW-1:0] rdata_q;

  title_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SRAM_DW)) u_fifo (
    .clk(Clk), .rst_n(Reset_n), .flush(frame_start),
    .push(fifo_push), .push_data(SRAM_DQ_in), .pop(pop),
    .head(word_out), .count(fifo_count), .empty(fifo_empty), .full(fifo_full)
  );

  assign inflight    = (state == DISP_ACC);
  assign occ         = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign last_cyc    = (acc_cnt == ACW'(ACCESS_CYCLES - 1));
  assign disp_more   = (fetch_cnt < FCW'(FRAME_WORDS));
  // A word fetched before a frame restart belongs to the old frame: drop it.
  assign fifo_push   = inflight && last_cyc && !flush_pend && !frame_start;
  assign word_valid  = !fifo_empty;
  assign underflow   = underflow_q;
  assign host_ack    = ack_q;
  assign host_rdata  = rdata_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_out = host_wdata;

  always_comb begin
    state_nxt  = state;
    grant_disp = 1'b0;
    grant_host = 1'b0;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_UB_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_DQ_oe = 1'b0;
    case (state)
      IDLE: begin
        // ack_q guard stops a just-acked host request being served twice.
        if (!frame_start && disp_more && occ < (CW+1)'(LOW_WATER))
          grant_disp = 1'b1;
        else if (host_req && !ack_q)
          grant_host = 1'b1;
        else if (!frame_start && disp_more && !fifo_full)
          grant_disp = 1'b1;
        if (grant_disp) state_nxt = DISP_ACC;
        if (grant_host) state_nxt = HOST_ACC;
      end
      DISP_ACC: begin
        {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N} = 4'b0000;
        if (last_cyc) state_nxt = IDLE;
      end
      HOST_ACC: begin
        {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} = 3'b000;
        if (host_we) begin
          SRAM_WE_N  = 1'b0;
          SRAM_DQ_oe = 1'b1;
        end else begin
          SRAM_OE_N  = 1'b0;
        end
        if (last_cyc) state_nxt = host_we ? TURN : IDLE;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      acc_cnt     <= '0;
      fetch_cnt   <= '0;
      addr_q      <= '0;
      flush_pend  <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ack_q   <= 1'b0;
      acc_cnt <= ((state == DISP_ACC || state == HOST_ACC) && !last_cyc) ?
                 acc_cnt + ACW'(1) : '0;
      if (grant_disp) begin
        addr_q    <= BASE_ADDR + SRAM_AW'(fetch_cnt);
        fetch_cnt <= fetch_cnt + FCW'(1);
      end
      if (grant_host) addr_q <= host_addr;
      if (frame_start) fetch_cnt <= '0;
      if (inflight && frame_start && !last_cyc) flush_pend <= 1'b1;
      else if (last_cyc)                        flush_pend <= 1'b0;
      if (state == HOST_ACC && last_cyc) begin
        ack_q <= 1'b1;
        if (!host_we) rdata_q <= SRAM_DQ_in;
      end
      if (frame_start)            underflow_q <= 1'b0;
      else if (pop && fifo_empty) underflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_title_sram_arbiter.sv
// Directed bench for title_sram_arbiter with a behavioural SRAM (mem[a] = a[15:0] unless written).
module tb_title_sram_arbiter;
  import title_arb_pkg::*;
  localparam int FW = 1100;

  logic Clk = 1'b0, Reset_n = 1'b1;
  logic frame_start = 1'b0, pop = 1'b0;
  logic [15:0] word_out;
  logic word_valid, underflow;
  logic host_req = 1'b0, host_we = 1'b0;
  logic [19:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic host_ack;
  logic [15:0] host_rdata;
  logic [19:0] SRAM_ADDR;
  logic SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic [15:0] SRAM_DQ_in = '0;
  logic [15:0] SRAM_DQ_out;
  logic SRAM_DQ_oe;

  always #10 Clk = ~Clk;

  title_sram_arbiter #(.FRAME_WORDS(FW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pop(pop),
    .word_out(word_out), .word_valid(word_valid), .underflow(underflow),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe)
  );

  typedef struct { bit we; logic [19:0] addr; } acc_t;
  typedef struct { bit we; logic [19:0] addr; logic [15:0] wdata; logic [15:0] exp_rdata; } hvec_t;

  logic [15:0] wmem [int];
  acc_t log_q[$];
  int n_chk = 0, n_pass = 0, proto_err = 0, ack_cnt = 0, run = 0;

  function automatic logic [15:0] mem_rd(input logic [19:0] a);
    return wmem.exists(int'(a)) ? wmem[int'(a)] : a[15:0];
  endfunction

  // SRAM model plus bus monitor: one log entry per access, strobe-pattern sanity.
  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) wmem[int'(SRAM_ADDR)] = SRAM_DQ_out;
    #1;
    SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem_rd(SRAM_ADDR) : 16'h0;
    if (!Reset_n) run = 0;
    if (!SRAM_CE_N) begin
      run++;
      if (run == 1) log_q.push_back('{we: !SRAM_WE_N, addr: SRAM_ADDR});
      if (SRAM_UB_N || SRAM_LB_N || (SRAM_OE_N == SRAM_WE_N)) proto_err++;
      if (SRAM_DQ_oe != !SRAM_WE_N) proto_err++;
    end else begin
      if (run != 0 && run != 2) proto_err++;
      run = 0;
      if (SRAM_DQ_oe || !SRAM_OE_N || !SRAM_WE_N) proto_err++;
    end
    if (host_ack) ack_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic host_op(input bit we, input logic [19:0] a, input logic [15:0] d, output int lat);
    @(negedge Clk);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; lat = 0;
    while (lat < 50) begin
      @(negedge Clk); lat++;
      if (host_ack) break;
    end
    host_req = 1'b0;
  endtask

  task automatic pulse_frame_start();
    @(negedge Clk); frame_start = 1'b1; log_q.delete();
    @(negedge Clk); frame_start = 1'b0;
  endtask

  initial begin
    hvec_t tbl[8];
    int lat, e, n, idx, k;
    bit fired;
    logic [19:0] a;

    tbl[0] = '{1'b1, 20'h40000, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b0, 20'h40000, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b0, 20'h00005, 16'h0000, 16'h0005};
    tbl[3] = '{1'b1, 20'h12345, 16'h1234, 16'h0005};
    tbl[4] = '{1'b0, 20'h12345, 16'h0000, 16'h1234};
    tbl[5] = '{1'b0, 20'hFFFFF, 16'h0000, 16'hFFFF};
    tbl[6] = '{1'b1, 20'hFFFFF, 16'hA5A5, 16'hFFFF};
    tbl[7] = '{1'b0, 20'hFFFFF, 16'h0000, 16'hA5A5};

    // Reset state
    #3 Reset_n = 1'b0;
    #20;
    chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
    chk("rst_dq_oe", SRAM_DQ_oe, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_ack_rdata", {host_ack, host_rdata}, 0);
    chk("rst_fifo", {word_valid, underflow}, 0);
    @(negedge Clk); Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    // Fill with no pops
    pulse_frame_start();
    repeat (100) @(negedge Clk);
    chk("fill_valid", word_valid, 1);
    chk("fill_head", word_out, 16'h0000);
    chk("fill_accesses", log_q.size(), 16);
    chk("fill_last_addr", SRAM_ADDR, 20'h0000F);

    // Host transactions while the FIFO is full
    foreach (tbl[i]) begin
      host_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat);
      chk($sformatf("host%0d_lat", i), lat, 3);
      chk($sformatf("host%0d_rdata", i), host_rdata, tbl[i].exp_rdata);
      if (tbl[i].we) begin
        chk($sformatf("host%0d_turn", i), {SRAM_CE_N, SRAM_DQ_oe}, 2'b10);
        chk($sformatf("host%0d_mem", i),
            wmem.exists(int'(tbl[i].addr)) ? wmem[int'(tbl[i].addr)] : 16'hDEAD, tbl[i].wdata);
      end
      @(negedge Clk);
      chk($sformatf("host%0d_ack_pulse", i), host_ack, 0);
    end

    // Urgent display beats a pending host request
    pulse_frame_start();
    host_req = 1'b1; host_we = 1'b0; host_addr = 20'h40000;
    for (k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (host_ack) break;
    end
    host_req = 1'b0;
    chk("urg_ack", host_ack, 1);
    chk("urg_rdata", host_rdata, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      a = (log_q.size() > i) ? log_q[i].addr : 20'hFFFFF;
      chk($sformatf("urg_order%0d", i), a, (i < 4) ? i : 32'h40000);
    end

    // Steady stream: one pop every 4 cycles
    for (e = 0; e < 1000; e++) begin
      @(negedge Clk);
      chk("stream", {word_valid, word_out}, {1'b1, e[15:0]});
      pop = 1'b1;
      @(negedge Clk); pop = 1'b0;
      repeat (2) @(negedge Clk);
    end
    chk("stream_underflow", underflow, 0);

    // Drain to end of frame
    for (k = 0; k < 3000 && e < FW; k++) begin
      @(negedge Clk);
      pop = 1'b0;
      if (word_valid) begin
        chk("drain", word_out, e);
        pop = 1'b1; e++;
      end
    end
    @(negedge Clk); pop = 1'b0;
    chk("drain_done", e, FW);
    repeat (30) @(negedge Clk);
    chk("eof_empty", word_valid, 0);
    chk("eof_hold", word_out, FW - 1);
    n = log_q.size();
    repeat (3) begin
      @(negedge Clk); pop = 1'b1;
      @(negedge Clk); pop = 1'b0;
    end
    @(negedge Clk);
    chk("empty_pop_underflow", underflow, 1);
    chk("empty_pop_valid", word_valid, 0);
    chk("empty_pop_hold", word_out, FW - 1);
    chk("eof_no_fetch", log_q.size(), n);

    // frame_start in the middle of the fetch of word 37
    pulse_frame_start();
    chk("fs_clr_underflow", underflow, 0);
    fired = 0; idx = 0;
    for (k = 0; k < 3000 && !fired; k++) begin
      @(negedge Clk);
      pop = 1'b0;
      if (log_q.size() > 0 && log_q[$].addr == 20'd37 && !SRAM_CE_N && !SRAM_OE_N) begin
        frame_start = 1'b1; fired = 1; idx = log_q.size();
        @(negedge Clk); frame_start = 1'b0;
      end else if (k % 4 == 0 && word_valid) pop = 1'b1;
    end
    chk("fs_fired", fired, 1);
    repeat (40) @(negedge Clk);
    a = (log_q.size() > idx) ? log_q[idx].addr : 20'hFFFFF;
    chk("fs_restart_addr", a, 0);
    chk("fs_underflow", underflow, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fs_head%0d", i), {word_valid, word_out}, {1'b1, 16'(i)});
      @(negedge Clk); pop = 1'b1;
      @(negedge Clk); pop = 1'b0;
    end

    // Reset during a host write
    @(negedge Clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00123; host_wdata = 16'h5555;
    for (k = 0; k < 50; k++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) break;
    end
    chk("rstw_we_seen", SRAM_WE_N, 0);
    n = ack_cnt;
    Reset_n = 1'b0;
    #1;
    chk("rstw_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
    chk("rstw_dq_oe", SRAM_DQ_oe, 0);
    chk("rstw_addr", SRAM_ADDR, 0);
    chk("rstw_rdata", {host_ack, host_rdata}, 0);
    chk("rstw_fifo", word_valid, 0);
    host_req = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rstw_no_ack", ack_cnt, n);

    chk("bus_protocol", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
